// File: rtl/i2c_master_ext.sv
// Byte-level I2C master with open-drain pad enables, SCL clock stretching with
// timeout, and multi-master arbitration-loss detection.
module i2c_master_ext #(
  parameter int unsigned DVSR_W     = 16,
  parameter bit          STRETCH_EN = 1'b1,
  parameter int unsigned TOUT_W     = 20
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [7:0]        din_i,
  input  logic [DVSR_W-1:0] dvsr_i,
  input  logic [2:0]        cmd_i,
  input  logic              wr_i2c_i,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              scl_oe_o,
  output logic              sda_oe_o,
  output logic              ready_o,
  output logic              done_tick_o,
  output logic              ack_o,
  output logic [7:0]        dout_o,
  output logic              arb_lost_o,
  output logic              timeout_o
);

  typedef enum logic [3:0] {
    StIdle, StStart1, StStart2, StHold, StData1, StData2, StData3, StData4,
    StDataEnd, StRestart, StStop1, StStop2
  } state_e;

  localparam logic [2:0] CmdStart   = 3'd0;
  localparam logic [2:0] CmdWr      = 3'd1;
  localparam logic [2:0] CmdRd      = 3'd2;
  localparam logic [2:0] CmdStop    = 3'd3;
  localparam logic [2:0] CmdRestart = 3'd4;
  // Last stretched cycle before the timeout limit is reached.
  localparam logic [TOUT_W-1:0] ToutLast = {TOUT_W{1'b1}} - TOUT_W'(1);

  state_e              state_q, state_d;
  logic [DVSR_W:0]     cnt_q, cnt_d;
  logic [DVSR_W-1:0]   qutr_q, qutr_d;
  logic [3:0]          bit_q, bit_d;
  logic [8:0]          tx_q, tx_d, rx_q, rx_d;
  logic                rd_q, rd_d;
  logic [TOUT_W-1:0]   tout_q, tout_d;
  logic                scl_oe_q, scl_oe_d, sda_oe_q, sda_oe_d;
  logic                done_q, done_d, ack_q, ack_d, arb_q, arb_d, tmo_q, tmo_d;
  logic [7:0]          dout_q, dout_d;

  logic [DVSR_W:0]     qutr, half, phase_len;
  logic                stretch_st, stretched, phase_end, tx_bit, abort;

  assign qutr       = (qutr_q == '0) ? {{DVSR_W{1'b0}}, 1'b1} : {1'b0, qutr_q};
  assign half       = qutr << 1;
  assign phase_len  = (state_q inside {StStart1, StStart2, StRestart, StStop1, StStop2}) ?
                      half : qutr;
  assign stretch_st = state_q inside {StData2, StData3, StRestart, StStop1, StStop2};
  // SCL is released in these phases; a low level means a slave is stretching.
  assign stretched  = STRETCH_EN && stretch_st && !scl_i;
  assign phase_end  = !stretched && (cnt_q == phase_len - 1'b1);

  // Next-state, datapath and next-output computation.
  always_comb begin
    state_d = state_q;
    qutr_d  = qutr_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rd_d    = rd_q;
    ack_d   = ack_q;
    dout_d  = dout_q;
    arb_d   = arb_q;
    tmo_d   = tmo_q;
    done_d  = 1'b0;
    abort   = 1'b0;
    cnt_d   = stretched ? '0 : cnt_q + 1'b1;
    tout_d  = stretched ? tout_q + 1'b1 : '0;

    case (state_q)
      StIdle: begin
        if (wr_i2c_i && cmd_i == CmdStart) begin
          state_d = StStart1;
          qutr_d  = dvsr_i;
          arb_d   = 1'b0;
          tmo_d   = 1'b0;
        end
      end
      StStart1:  if (phase_end) state_d = StStart2;
      StStart2:  if (phase_end) state_d = StHold;
      StHold: begin
        if (wr_i2c_i) begin
          case (cmd_i)
            CmdStart, CmdRestart: state_d = StRestart;
            CmdStop:              state_d = StStop1;
            CmdWr, CmdRd: begin
              state_d = StData1;
              tx_d    = {din_i, din_i[0]};
              rd_d    = (cmd_i == CmdRd);
              bit_d   = 4'd0;
            end
            default: state_d = StHold;
          endcase
        end
      end
      StData1:   if (phase_end) state_d = StData2;
      StData2: begin
        if (phase_end) begin
          rx_d = {rx_q[7:0], sda_i};
          // Released 1 on a written data bit but the bus reads 0: another master won.
          if (!rd_q && bit_q < 4'd8 && tx_q[8] && !sda_i) begin
            arb_d = 1'b1;
            abort = 1'b1;
          end else begin
            state_d = StData3;
          end
        end
      end
      StData3:   if (phase_end) state_d = StData4;
      StData4: begin
        if (phase_end) begin
          if (bit_q == 4'd8) begin
            state_d = StDataEnd;
            done_d  = 1'b1;
            dout_d  = rx_q[8:1];
            ack_d   = rx_q[0];
          end else begin
            state_d = StData1;
            bit_d   = bit_q + 4'd1;
            tx_d    = {tx_q[7:0], 1'b0};
          end
        end
      end
      StDataEnd: if (phase_end) state_d = StHold;
      StRestart: if (phase_end) state_d = StStart1;
      StStop1:   if (phase_end) state_d = StStop2;
      StStop2: begin
        if (cnt_q == '0 && !sda_i) begin
          arb_d = 1'b1;
          abort = 1'b1;
        end else if (phase_end) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (stretched && tout_q == ToutLast) begin
      tmo_d = 1'b1;
      abort = 1'b1;
    end
    if (abort) begin
      state_d = StIdle;
      done_d  = 1'b0;
      tout_d  = '0;
    end
    if (state_d != state_q || state_q inside {StIdle, StHold}) cnt_d = '0;

    // Bit the master wants on SDA in the data phases (1 = released).
    if (rd_d) tx_bit = (bit_d == 4'd8) ? tx_d[8] : 1'b1;
    else      tx_bit = (bit_d == 4'd8) ? 1'b1 : tx_d[8];

    scl_oe_d = state_d inside {StStart2, StHold, StData1, StData4, StDataEnd};
    case (state_d)
      StStart1, StStart2, StHold, StDataEnd, StStop1: sda_oe_d = 1'b1;
      StData1, StData2, StData3, StData4:             sda_oe_d = ~tx_bit;
      default:                                        sda_oe_d = 1'b0;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      qutr_q   <= '0;
      bit_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      rd_q     <= 1'b0;
      tout_q   <= '0;
      scl_oe_q <= 1'b0;
      sda_oe_q <= 1'b0;
      done_q   <= 1'b0;
      ack_q    <= 1'b0;
      dout_q   <= '0;
      arb_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      qutr_q   <= qutr_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      rd_q     <= rd_d;
      tout_q   <= tout_d;
      scl_oe_q <= scl_oe_d;
      sda_oe_q <= sda_oe_d;
      done_q   <= done_d;
      ack_q    <= ack_d;
      dout_q   <= dout_d;
      arb_q    <= arb_d;
      tmo_q    <= tmo_d;
    end
  end

  assign ready_o     = (state_q == StIdle) || (state_q == StHold);
  assign scl_oe_o    = scl_oe_q;
  assign sda_oe_o    = sda_oe_q;
  assign done_tick_o = done_q;
  assign ack_o       = ack_q;
  assign dout_o      = dout_q;
  assign arb_lost_o  = arb_q;
  assign timeout_o   = tmo_q;

endmodule

// File: tb/tb_i2c_master_ext.sv
// Directed bench for i2c_master_ext with a cycle-level open-drain bus and slave model.
module tb_i2c_master_ext;
  localparam int unsigned DvsrW = 16;

  logic             clk, rst_n;
  logic [7:0]       din;
  logic [DvsrW-1:0] dvsr;
  logic [2:0]       cmd;
  logic             wr;
  logic             scl_bus, sda_bus;
  logic             scl_oe, sda_oe, ready, done, ack, arb, tmo;
  logic [7:0]       dout;
  logic             slv_scl_low, slv_sda_low;
  int               n_cmp = 0;
  int               n_bad = 0;
  int               n_done = 0;

  assign scl_bus = ~scl_oe & ~slv_scl_low;
  assign sda_bus = ~sda_oe & ~slv_sda_low;

  i2c_master_ext #(.DVSR_W(DvsrW), .STRETCH_EN(1'b1), .TOUT_W(6)) dut (
    .clk_i(clk), .rst_ni(rst_n), .din_i(din), .dvsr_i(dvsr), .cmd_i(cmd),
    .wr_i2c_i(wr), .scl_i(scl_bus), .sda_i(sda_bus), .scl_oe_o(scl_oe),
    .sda_oe_o(sda_oe), .ready_o(ready), .done_tick_o(done), .ack_o(ack),
    .dout_o(dout), .arb_lost_o(arb), .timeout_o(tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts every done pulse over the whole run, independent of resets.
  always @(posedge clk) if (done === 1'b1) n_done <= n_done + 1;

  task automatic send_cmd(input logic [2:0] c, input logic [7:0] d, input logic [DvsrW-1:0] dv);
    int k;
    k = 0;
    @(negedge clk);
    while (ready !== 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (ready !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL cmd_ready_wait: ready_o=%b required 1", ready);
    end
    cmd = c; din = d; dvsr = dv; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int k;
    k = 0;
    while (ready !== 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (ready !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: ready_o=%b required 1 within 2000 cycles", name, ready);
    end
  endtask

  // One byte; sbits is what the slave puts on SDA per bit (1 = release), MSB first.
  task automatic byte_xfer(input logic [2:0] c, input logic [7:0] d, input logic [8:0] sbits,
                           input int st_bit, input int st_len,
                           output int cyc, output int st_cyc, output int hi_cnt,
                           output logic [8:0] seen, output logic [8:0] mrel, output int nrise,
                           output bit got_done, output bit got_abort);
    int fidx, hold;
    logic scl_prev, oe_prev, scl_now, sda_now;
    bit st_done;
    cyc = 0; st_cyc = 0; hi_cnt = 0; seen = '0; mrel = '0; nrise = 0;
    got_done = 0; got_abort = 0; fidx = 0; hold = 0; st_done = 0;
    scl_prev = 1'b0; oe_prev = 1'b1;
    slv_sda_low = ~sbits[8];
    send_cmd(c, d, dvsr);
    for (int i = 0; i < 3000; i++) begin
      if (done === 1'b1) begin got_done = 1; break; end
      if (arb === 1'b1 || tmo === 1'b1) begin got_abort = 1; break; end
      if (scl_oe && !oe_prev) begin
        fidx++;
        slv_sda_low = (fidx < 9) ? ~sbits[8-fidx] : 1'b0;
      end
      if (!scl_oe && oe_prev && fidx == st_bit && !st_done) begin
        hold = st_len; st_done = 1; st_cyc = cyc;
      end
      slv_scl_low = (hold > 0);
      if (hold > 0) hold--;
      scl_now = ~scl_oe & ~slv_scl_low;
      sda_now = ~sda_oe & ~slv_sda_low;
      if (scl_now && !scl_prev && nrise < 9) begin
        seen[8-nrise] = sda_now;
        mrel[8-nrise] = ~sda_oe;
        nrise++;
      end
      if (scl_now && fidx == st_bit) hi_cnt++;
      scl_prev = scl_now; oe_prev = scl_oe;
      @(negedge clk);
      cyc++;
    end
    if (!got_done && !got_abort) begin
      n_cmp++; n_bad++;
      $display("FAIL xfer_end: no done or abort within 3000 cycles");
    end
    slv_scl_low = 1'b0; slv_sda_low = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (scl_oe !== 1'b0) begin n_bad++; $display("FAIL rst_scl_oe: got %b want 0", scl_oe); end
    n_cmp++; if (sda_oe !== 1'b0) begin n_bad++; $display("FAIL rst_sda_oe: got %b want 0", sda_oe); end
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", ready); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", done); end
    n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL rst_ack: got %b want 0", ack); end
    n_cmp++; if (dout !== 8'h00) begin n_bad++; $display("FAIL rst_dout: got %h want 00", dout); end
    n_cmp++; if (arb !== 1'b0) begin n_bad++; $display("FAIL rst_arb: got %b want 0", arb); end
    n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL rst_tmo: got %b want 0", tmo); end
    rst_n = 1'b1;
    // A WR in Idle must be ignored.
    send_cmd(3'd1, 8'h00, 16'd4);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (scl_oe !== 1'b0 || sda_oe !== 1'b0 || ready !== 1'b1) begin
      n_bad++;
      $display("FAIL idle_ignore_wr: scl_oe=%b sda_oe=%b ready=%b want 0 0 1", scl_oe, sda_oe, ready);
    end
  endtask

  task automatic do_start(input logic [DvsrW-1:0] dv);
    send_cmd(3'd0, 8'h00, dv);
    wait_ready("start_done");
  endtask

  task automatic do_stop(input string name);
    send_cmd(3'd3, 8'h00, dvsr);
    wait_ready(name);
    n_cmp++;
    if (scl_oe !== 1'b0 || sda_oe !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: scl_oe=%b sda_oe=%b want 0 0", name, scl_oe, sda_oe);
    end
  endtask

  task automatic test_write;
    int cyc, st_cyc, hi, nr; logic [8:0] seen, mrel; bit gd, ga;
    do_start(16'd4);
    n_cmp++;
    if (scl_oe !== 1'b1 || sda_oe !== 1'b1) begin
      n_bad++; $display("FAIL hold_lines: scl_oe=%b sda_oe=%b want 1 1", scl_oe, sda_oe);
    end
    byte_xfer(3'd1, 8'hA5, 9'b1_1111_1110, -1, 0, cyc, st_cyc, hi, seen, mrel, nr, gd, ga);
    n_cmp++; if (!gd) begin n_bad++; $display("FAIL wr_done: got %b want 1", gd); end
    n_cmp++; if (cyc != 144) begin n_bad++; $display("FAIL wr_latency: got %0d want 144", cyc); end
    n_cmp++; if (seen !== 9'h14A) begin n_bad++; $display("FAIL wr_sda_pattern: got %h want 14a", seen); end
    n_cmp++; if (mrel !== 9'h14B) begin n_bad++; $display("FAIL wr_master_release: got %h want 14b", mrel); end
    n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL wr_ack: got %b want 0", ack); end
    n_cmp++; if (dout !== 8'hA5) begin n_bad++; $display("FAIL wr_dout: got %h want a5", dout); end
    do_stop("wr_stop_release");
  endtask

  task automatic test_read;
    int cyc, st_cyc, hi, nr; logic [8:0] seen, mrel; bit gd, ga;
    do_start(16'd2);
    byte_xfer(3'd2, 8'h01, {8'h3C, 1'b1}, -1, 0, cyc, st_cyc, hi, seen, mrel, nr, gd, ga);
    n_cmp++; if (cyc != 72) begin n_bad++; $display("FAIL rd_latency: got %0d want 72", cyc); end
    n_cmp++; if (dout !== 8'h3C) begin n_bad++; $display("FAIL rd_dout: got %h want 3c", dout); end
    n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL rd_ack: got %b want 1", ack); end
    n_cmp++; if (mrel !== 9'h1FF) begin n_bad++; $display("FAIL rd_master_release: got %h want 1ff", mrel); end
    n_cmp++; if (seen !== 9'h079) begin n_bad++; $display("FAIL rd_bus: got %h want 079", seen); end
    do_stop("rd_stop_release");
  endtask

  task automatic test_stretch;
    int cyc, st_cyc, hi, nr; logic [8:0] seen, mrel; bit gd, ga;
    do_start(16'd4);
    byte_xfer(3'd1, 8'hA5, 9'b1_1111_1110, 2, 50, cyc, st_cyc, hi, seen, mrel, nr, gd, ga);
    n_cmp++; if (cyc != 194) begin n_bad++; $display("FAIL st_latency: got %0d want 194", cyc); end
    n_cmp++; if (hi != 8) begin n_bad++; $display("FAIL st_scl_high: got %0d want 8", hi); end
    n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL st_timeout: got %b want 0", tmo); end
    n_cmp++; if (seen !== 9'h14A) begin n_bad++; $display("FAIL st_sda_pattern: got %h want 14a", seen); end
  endtask

  task automatic test_timeout;
    int cyc, st_cyc, hi, nr; logic [8:0] seen, mrel; bit gd, ga;
    byte_xfer(3'd1, 8'h00, 9'h1FF, 0, 1000, cyc, st_cyc, hi, seen, mrel, nr, gd, ga);
    n_cmp++; if (tmo !== 1'b1) begin n_bad++; $display("FAIL to_flag: got %b want 1", tmo); end
    n_cmp++; if (cyc - st_cyc != 63) begin n_bad++; $display("FAIL to_cycles: got %0d want 63", cyc - st_cyc); end
    n_cmp++; if (gd) begin n_bad++; $display("FAIL to_no_done: got %b want 0", gd); end
    n_cmp++;
    if (ready !== 1'b1 || scl_oe !== 1'b0 || sda_oe !== 1'b0) begin
      n_bad++; $display("FAIL to_idle: ready=%b scl_oe=%b sda_oe=%b want 1 0 0", ready, scl_oe, sda_oe);
    end
    send_cmd(3'd0, 8'h00, 16'd4);
    n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL to_clear: got %b want 0", tmo); end
    wait_ready("to_restart");
  endtask

  task automatic test_arb;
    int cyc, st_cyc, hi, nr; logic [8:0] seen, mrel; bit gd, ga;
    byte_xfer(3'd1, 8'hFF, 9'b1_0111_1111, -1, 0, cyc, st_cyc, hi, seen, mrel, nr, gd, ga);
    n_cmp++; if (arb !== 1'b1) begin n_bad++; $display("FAIL arb_flag: got %b want 1", arb); end
    n_cmp++; if (nr != 2) begin n_bad++; $display("FAIL arb_bit: got %0d want 2", nr); end
    n_cmp++;
    if (scl_oe !== 1'b0 || sda_oe !== 1'b0 || ready !== 1'b1) begin
      n_bad++; $display("FAIL arb_release: scl_oe=%b sda_oe=%b ready=%b want 0 0 1", scl_oe, sda_oe, ready);
    end
    n_cmp++; if (gd) begin n_bad++; $display("FAIL arb_no_done: got %b want 0", gd); end
  endtask

  task automatic test_mid_reset;
    int cyc, st_cyc, hi, nr; logic [8:0] seen, mrel; bit gd, ga;
    do_start(16'd4);
    send_cmd(3'd1, 8'h00, 16'd4);
    repeat (65) @(negedge clk);
    n_cmp++;
    if (scl_oe !== 1'b1 || sda_oe !== 1'b1) begin
      n_bad++; $display("FAIL mr_pre: scl_oe=%b sda_oe=%b want 1 1", scl_oe, sda_oe);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (scl_oe !== 1'b0 || sda_oe !== 1'b0 || ready !== 1'b1 || dout !== 8'h00 || ack !== 1'b0) begin
      n_bad++;
      $display("FAIL mr_async: scl_oe=%b sda_oe=%b ready=%b dout=%h ack=%b want 0 0 1 00 0",
               scl_oe, sda_oe, ready, dout, ack);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_start(16'd4);
    byte_xfer(3'd1, 8'h5A, 9'b1_1111_1110, -1, 0, cyc, st_cyc, hi, seen, mrel, nr, gd, ga);
    n_cmp++; if (cyc != 144) begin n_bad++; $display("FAIL mr_latency: got %0d want 144", cyc); end
    n_cmp++; if (dout !== 8'h5A) begin n_bad++; $display("FAIL mr_dout: got %h want 5a", dout); end
    n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL mr_ack: got %b want 0", ack); end
    do_stop("mr_stop_release");
  endtask

  initial begin
    rst_n = 1'b0; wr = 1'b0; cmd = 3'd0; din = 8'h00; dvsr = '0;
    slv_scl_low = 1'b0; slv_sda_low = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_stretch();
    test_timeout();
    test_arb();
    test_mid_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (n_done != 4) begin n_bad++; $display("FAIL done_count: got %0d want 4", n_done); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
